// File: rtl/addsub_pkg.sv
// Shared definitions for the addsub datapath: nibble width, FSM states and
// a constant-width helper for the nibble counter.
package addsub_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Bits needed to count 0..n-1; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// Operand request / result handshake bundle for nibble_serial_addsub.
interface nibble_serial_addsub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             i_valid;
    logic             o_ready;
    logic             i_sub;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_result;
    logic             o_cout;
    logic             o_overflow;

    modport master (
        output i_valid, i_sub, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_result, o_cout, o_overflow
    );

    modport slave (
        input  i_valid, i_sub, i_a, i_b, i_ready,
        output o_ready, o_valid, o_result, o_cout, o_overflow
    );
endinterface

// File: rtl/nibble_serial_addsub_slice.sv
// 4-bit ripple-carry adder used as the per-cycle nibble slice.
module ripple_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    always_comb begin : chain
        logic [4:0] c;
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end
endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit add/subtract: one nibble per cycle through a 4-bit
// ripple slice, carry held between cycles, result presented on a held handshake.
module nibble_serial_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    nibble_serial_addsub_if.slave  bus
);
    localparam int unsigned N     = WIDTH / NIBBLE_W;
    localparam int unsigned CNT_W = clog2(N);

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic               carry_q;
    logic               a_msb;
    logic               b_msb;
    logic [CNT_W-1:0]   cnt;

    logic               ready_q;
    logic               valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               cout_q;
    logic               ovf_q;

    logic [3:0]         slice_sum;
    logic               slice_cout;
    logic [WIDTH-1:0]   res_next;

    ripple_adder_4bit u_slice (
        .a    (a_sr[3:0]),
        .b    (b_sr[3:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Sum nibbles enter from the top so nibble 0 lands at [3:0] after N shifts.
    assign res_next = {slice_sum, res_sr[WIDTH-1:NIBBLE_W]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            carry_q  <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            cnt      <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_valid) begin
                        a_sr    <= bus.i_a;
                        b_sr    <= bus.i_sub ? ~bus.i_b : bus.i_b;
                        carry_q <= bus.i_sub;
                        a_msb   <= bus.i_a[WIDTH-1];
                        b_msb   <= bus.i_sub ? ~bus.i_b[WIDTH-1] : bus.i_b[WIDTH-1];
                        res_sr  <= '0;
                        cnt     <= '0;
                        ready_q <= 1'b0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res_sr  <= res_next;
                    a_sr    <= a_sr >> NIBBLE_W;
                    b_sr    <= b_sr >> NIBBLE_W;
                    carry_q <= slice_cout;
                    cnt     <= cnt + 1'b1;
                    // Outputs load from the final slice result so they appear with o_valid.
                    if (cnt == CNT_W'(N - 1)) begin
                        valid_q  <= 1'b1;
                        result_q <= res_next;
                        cout_q   <= slice_cout;
                        ovf_q    <= (a_msb == b_msb) && (slice_sum[3] != a_msb);
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.i_ready) begin
                        valid_q  <= 1'b0;
                        result_q <= '0;
                        cout_q   <= 1'b0;
                        ovf_q    <= 1'b0;
                        ready_q  <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_ready    = ready_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_result   = result_q;
    assign bus.o_cout     = cout_q;
    assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed self-checking bench for nibble_serial_addsub at WIDTH=16.
module tb_nibble_serial_addsub;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    nibble_serial_addsub_if #(.WIDTH(16)) bus ();

    nibble_serial_addsub #(.WIDTH(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Issue one operation and wait for o_valid; sampling is 1ns after edges.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input logic rdy, output int lat, output bit timeout);
        int w;
        timeout = 1'b0;
        lat = 0;
        bus.i_a = a; bus.i_b = b; bus.i_sub = sub; bus.i_ready = rdy; bus.i_valid = 1'b1;
        w = 0;
        while (!bus.o_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (!bus.o_ready) timeout = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        while (!bus.o_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!bus.o_valid) timeout = 1'b1;
    endtask

    task automatic test_reset();
        bus.i_valid = 1'b0; bus.i_ready = 1'b0; bus.i_sub = 1'b0;
        bus.i_a = '0; bus.i_b = '0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: ready=%b valid=%b expected ready=1 valid=0", bus.o_ready, bus.o_valid);
        end
        checks++;
        if ({bus.o_result, bus.o_cout, bus.o_overflow} !== 18'h0) begin
            failures++;
            $display("FAIL reset_outputs: result=%h cout=%b ovf=%b expected 0000 0 0", bus.o_result, bus.o_cout, bus.o_overflow);
        end
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        logic [15:0] ta [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [15:0] tb [5] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
        logic        ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] er [5] = '{16'h2233, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
        logic        ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int lat;
        bit to;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], ts[i], 1'b1, lat, to);
            checks++;
            if (to !== 1'b0 || lat !== 4) begin
                failures++;
                $display("FAIL arith_latency[%0d]: lat=%0d timeout=%b expected lat=4", i, lat, to);
            end
            checks++;
            if (bus.o_result !== er[i]) begin
                failures++;
                $display("FAIL arith_result[%0d]: got %h expected %h", i, bus.o_result, er[i]);
            end
            checks++;
            if (bus.o_cout !== ec[i] || bus.o_overflow !== eo[i]) begin
                failures++;
                $display("FAIL arith_flags[%0d]: cout=%b ovf=%b expected cout=%b ovf=%b", i, bus.o_cout, bus.o_overflow, ec[i], eo[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        run_op(16'h00F0, 16'h0F0F, 1'b0, 1'b0, lat, to);
        checks++;
        if (to !== 1'b0 || bus.o_result !== 16'h0FFF) begin
            failures++;
            $display("FAIL bp_first: result=%h timeout=%b expected 0fff", bus.o_result, to);
        end
        bus.i_a = 16'h1111; bus.i_b = 16'h2222; bus.i_sub = 1'b0; bus.i_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_result !== 16'h0FFF ||
                bus.o_cout !== 1'b0 || bus.o_overflow !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b result=%h cout=%b ovf=%b expected 1 0 0fff 0 0",
                         c, bus.o_valid, bus.o_ready, bus.o_result, bus.o_cout, bus.o_overflow);
            end
        end
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_result !== 16'h0000) begin
            failures++;
            $display("FAIL bp_release: ready=%b valid=%b result=%h expected 1 0 0000", bus.o_ready, bus.o_valid, bus.o_result);
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        checks++;
        if (bus.o_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_reaccept: ready=%b expected 0", bus.o_ready);
        end
        lat = 0;
        while (!bus.o_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== 4 || bus.o_result !== 16'h3333) begin
            failures++;
            $display("FAIL bp_second: lat=%0d result=%h expected lat=4 3333", lat, bus.o_result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int          cyc = 0;
        int          n_acc = 0;
        int          n_res = 0;
        int          acc_cyc [2];
        logic [15:0] res [2];
        bit          acc;
        bit          both_high = 1'b0;
        bus.i_ready = 1'b1; bus.i_sub = 1'b0;
        bus.i_a = 16'h0001; bus.i_b = 16'h0001; bus.i_valid = 1'b1;
        while (n_res < 2 && cyc < 40) begin
            acc = bus.o_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                bus.i_a = 16'h00FF; bus.i_b = 16'h0001;
            end
            if (bus.o_valid && bus.o_ready) both_high = 1'b1;
            if (bus.o_valid) begin
                res[n_res] = bus.o_result;
                n_res++;
            end
        end
        bus.i_valid = 1'b0;
        checks++;
        if (n_res !== 2 || n_acc !== 2) begin
            failures++;
            $display("FAIL b2b_progress: accepts=%0d results=%0d expected 2 2", n_acc, n_res);
        end else begin
            checks++;
            if (acc_cyc[1] - acc_cyc[0] !== 6) begin
                failures++;
                $display("FAIL b2b_interval: got %0d expected 6", acc_cyc[1] - acc_cyc[0]);
            end
            checks++;
            if (res[0] !== 16'h0002 || res[1] !== 16'h0100) begin
                failures++;
                $display("FAIL b2b_results: got %h %h expected 0002 0100", res[0], res[1]);
            end
        end
        checks++;
        if (both_high !== 1'b0) begin
            failures++;
            $display("FAIL b2b_exclusive: ready and valid high together=%b expected 0", both_high);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit to;
        bit stale = 1'b0;
        bus.i_ready = 1'b1; bus.i_sub = 1'b0;
        bus.i_a = 16'h1234; bus.i_b = 16'h1111; bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_result !== 16'h0000) begin
            failures++;
            $display("FAIL midrun_reset: ready=%b valid=%b result=%h expected 1 0 0000", bus.o_ready, bus.o_valid, bus.o_result);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bus.o_valid !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin
            failures++;
            $display("FAIL midrun_stale: valid seen=%b expected 0", stale);
        end
        run_op(16'h0010, 16'h0020, 1'b0, 1'b1, lat, to);
        checks++;
        if (to !== 1'b0 || bus.o_result !== 16'h0030 || bus.o_cout !== 1'b0 || bus.o_overflow !== 1'b0) begin
            failures++;
            $display("FAIL midrun_next: result=%h cout=%b ovf=%b timeout=%b expected 0030 0 0 0",
                     bus.o_result, bus.o_cout, bus.o_overflow, to);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
